// File: rtl/uart_fifo16x.sv
// rtl/uart_fifo16x.sv - UART with TX/RX FIFOs, 16x RX oversampling, parity, loopback and one irq.
// Register file on a 3-bit address bus; the FIFO helper lives at the bottom of this file.

module uart_fifo16x #(
   parameter int          FIFO_DEPTH = 16,
   parameter logic [15:0] DIV_RESET  = 16'd27
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic       tx,
   input  logic [2:0] addr,
   input  logic       write_en,
   input  logic       read_en,
   input  logic [7:0] write_data,
   output logic [7:0] read_data,
   output logic       irq
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

   function automatic logic [7:0] sat8(input logic [8:0] c);
      return c[8] ? 8'hFF : c[7:0];
   endfunction

   function automatic logic [7:0] data_mask(input logic [1:0] nb);
      return 8'hFF >> (2'd3 - nb);
   endfunction

   logic [7:0]  ctrl_q, ctrl_d;
   logic [15:0] div_q, div_d, baud_cnt_q, baud_cnt_d, div_eff;
   logic        tick16;
   logic        rx_meta_q, rx_sync_q, rx_in;

   tx_state_e   tx_state_q, tx_state_d;
   logic        tx_q, tx_d, tx_pop, tx_bit_end;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [3:0]  tx_tick_q, tx_tick_d;
   logic [1:0]  tx_nbits_q, tx_nbits_d;
   logic        tx_two_stop_q, tx_two_stop_d, tx_par_en_q, tx_par_en_d;
   logic        tx_par_q, tx_par_d, tx_stop2_q, tx_stop2_d;

   rx_state_e   rx_state_q, rx_state_d;
   logic [3:0]  rx_tick_q, rx_tick_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d, rx_data;
   logic [1:0]  rx_nbits_q, rx_nbits_d;
   logic        rx_par_en_q, rx_par_en_d, rx_odd_q, rx_odd_d, rx_par_bit_q, rx_par_bit_d;
   logic        rx_push_q, rx_push_d, rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;
   logic [7:0]  rx_push_data_q, rx_push_data_d;
   logic        rx_bit_end;

   logic        overrun_q, overrun_d, parity_err_q, parity_err_d, framing_err_q, framing_err_d;
   logic        irq_q, irq_d;

   logic        wr_data, wr_status, wr_ctrl, wr_div_lo, wr_div_hi, rx_pop;
   logic [7:0]  tx_head, rx_head, status;
   logic [AW:0] tx_count, rx_count;
   logic        tx_empty, tx_full, rx_empty, rx_full;

   assign wr_data   = write_en & (addr == 3'd0);
   assign wr_status = write_en & (addr == 3'd1);
   assign wr_ctrl   = write_en & (addr == 3'd2);
   assign wr_div_lo = write_en & (addr == 3'd3);
   assign wr_div_hi = write_en & (addr == 3'd4);
   assign rx_pop    = read_en & (addr == 3'd0);

   uart_fifo16x_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst_n(rst_n), .push(wr_data), .push_data(write_data),
      .pop(tx_pop), .head(tx_head), .count(tx_count), .empty(tx_empty), .full(tx_full)
   );

   uart_fifo16x_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst_n(rst_n), .push(rx_push_q), .push_data(rx_push_data_q),
      .pop(rx_pop), .head(rx_head), .count(rx_count), .empty(rx_empty), .full(rx_full)
   );

   // A divisor of zero behaves as one so the baud tick never stalls.
   assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
   assign tick16  = baud_cnt_q >= (div_eff - 16'd1);
   assign rx_in   = ctrl_q[7] ? tx_q : rx_sync_q;
   assign tx      = ctrl_q[7] ? 1'b1 : tx_q;
   assign irq     = irq_q;

   always_comb begin
      ctrl_d     = wr_ctrl ? write_data : ctrl_q;
      div_d      = div_q;
      if (wr_div_lo) div_d[7:0]  = write_data;
      if (wr_div_hi) div_d[15:8] = write_data;
      baud_cnt_d = (wr_div_lo | wr_div_hi | tick16) ? 16'd0 : baud_cnt_q + 16'd1;
   end

   assign tx_bit_end = tick16 & (tx_tick_q == 4'hF);

   always_comb begin
      tx_state_d    = tx_state_q;
      tx_d          = tx_q;
      tx_shift_d    = tx_shift_q;
      tx_bit_d      = tx_bit_q;
      tx_tick_d     = tx_tick_q;
      tx_nbits_d    = tx_nbits_q;
      tx_two_stop_d = tx_two_stop_q;
      tx_par_en_d   = tx_par_en_q;
      tx_par_d      = tx_par_q;
      tx_stop2_d    = tx_stop2_q;
      tx_pop        = 1'b0;
      if (tx_state_q != TX_IDLE && tick16) tx_tick_d = tx_tick_q + 4'd1;
      case (tx_state_q)
         TX_IDLE: begin
            tx_d = 1'b1;
            if (!tx_empty) begin
               tx_pop        = 1'b1;
               tx_d          = 1'b0;
               tx_state_d    = TX_START;
               tx_tick_d     = 4'd0;
               tx_shift_d    = tx_head;
               tx_nbits_d    = ctrl_q[1:0];
               tx_two_stop_d = ctrl_q[2];
               tx_par_en_d   = ctrl_q[3];
               tx_par_d      = (^(tx_head & data_mask(ctrl_q[1:0]))) ^ ctrl_q[4];
               tx_stop2_d    = 1'b0;
            end
         end
         TX_START: if (tx_bit_end) begin
            tx_state_d = TX_DATA;
            tx_d       = tx_shift_q[0];
            tx_bit_d   = 3'd0;
         end
         TX_DATA: if (tx_bit_end) begin
            // Last data bit index is nbits-1, i.e. 4 + the CTRL field.
            if (tx_bit_q == {1'b1, tx_nbits_q}) begin
               tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP;
               tx_d       = tx_par_en_q ? tx_par_q : 1'b1;
            end else begin
               tx_shift_d = tx_shift_q >> 1;
               tx_d       = tx_shift_q[1];
               tx_bit_d   = tx_bit_q + 3'd1;
            end
         end
         TX_PARITY: if (tx_bit_end) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
         end
         TX_STOP: if (tx_bit_end) begin
            if (tx_two_stop_q && !tx_stop2_q) tx_stop2_d = 1'b1;
            else                              tx_state_d = TX_IDLE;
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   assign rx_bit_end = tick16 & (rx_tick_q == 4'hF);
   assign rx_data    = rx_shift_q >> (2'd3 - rx_nbits_q);

   always_comb begin
      rx_state_d     = rx_state_q;
      rx_tick_d      = rx_tick_q;
      rx_bit_d       = rx_bit_q;
      rx_shift_d     = rx_shift_q;
      rx_nbits_d     = rx_nbits_q;
      rx_par_en_d    = rx_par_en_q;
      rx_odd_d       = rx_odd_q;
      rx_par_bit_d   = rx_par_bit_q;
      rx_push_d      = 1'b0;
      rx_push_data_d = rx_push_data_q;
      rx_perr_d      = rx_perr_q;
      rx_ferr_d      = rx_ferr_q;
      if (rx_state_q != RX_IDLE && tick16) rx_tick_d = rx_tick_q + 4'd1;
      case (rx_state_q)
         RX_IDLE: if (!rx_in) begin
            rx_state_d  = RX_START;
            rx_tick_d   = 4'd0;
            rx_nbits_d  = ctrl_q[1:0];
            rx_par_en_d = ctrl_q[3];
            rx_odd_d    = ctrl_q[4];
         end
         // Half a bit in: recheck the line, then realign the tick count to bit centres.
         RX_START: if (tick16 && rx_tick_q == 4'd7) begin
            rx_tick_d  = 4'd0;
            rx_bit_d   = 3'd0;
            rx_state_d = rx_in ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (rx_bit_end) begin
            rx_shift_d = {rx_in, rx_shift_q[7:1]};
            if (rx_bit_q == {1'b1, rx_nbits_q}) rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
            else                                rx_bit_d   = rx_bit_q + 3'd1;
         end
         RX_PARITY: if (rx_bit_end) begin
            rx_par_bit_d = rx_in;
            rx_state_d   = RX_STOP;
         end
         RX_STOP: if (rx_bit_end) begin
            rx_push_d      = 1'b1;
            rx_push_data_d = rx_data;
            rx_perr_d      = rx_par_en_q & (rx_par_bit_q ^ (^rx_data) ^ rx_odd_q);
            rx_ferr_d      = ~rx_in;
            rx_state_d     = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Error flags: a same-cycle set beats the CPU's write-one-to-clear.
   always_comb begin
      overrun_d     = (overrun_q & ~(wr_status & write_data[4]))
                    | (rx_push_q & rx_full & ~rx_pop);
      parity_err_d  = (parity_err_q & ~(wr_status & write_data[5])) | (rx_push_q & rx_perr_q);
      framing_err_d = (framing_err_q & ~(wr_status & write_data[6])) | (rx_push_q & rx_ferr_q);
      irq_d         = (ctrl_q[5] & ~rx_empty) | (ctrl_q[6] & tx_empty)
                    | overrun_q | parity_err_q | framing_err_q;
   end

   assign status = {tx_empty & (tx_state_q == TX_IDLE), framing_err_q, parity_err_q, overrun_q,
                    rx_full, ~rx_empty, tx_full, tx_empty};

   always_comb begin
      read_data = 8'h00;
      case (addr)
         3'd0: read_data = rx_empty ? 8'h00 : rx_head;
         3'd1: read_data = status;
         3'd2: read_data = ctrl_q;
         3'd3: read_data = div_q[7:0];
         3'd4: read_data = div_q[15:8];
         3'd5: read_data = sat8(9'(rx_count));
         3'd6: read_data = sat8(9'(tx_count));
         default: read_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q <= 8'h03;  div_q <= DIV_RESET;  baud_cnt_q <= 16'd0;
         rx_meta_q <= 1'b1;  rx_sync_q <= 1'b1;
         tx_state_q <= TX_IDLE;  tx_q <= 1'b1;  tx_shift_q <= 8'h00;  tx_bit_q <= 3'd0;
         tx_tick_q <= 4'd0;  tx_nbits_q <= 2'd3;  tx_two_stop_q <= 1'b0;  tx_par_en_q <= 1'b0;
         tx_par_q <= 1'b0;  tx_stop2_q <= 1'b0;
         rx_state_q <= RX_IDLE;  rx_tick_q <= 4'd0;  rx_bit_q <= 3'd0;  rx_shift_q <= 8'h00;
         rx_nbits_q <= 2'd3;  rx_par_en_q <= 1'b0;  rx_odd_q <= 1'b0;  rx_par_bit_q <= 1'b0;
         rx_push_q <= 1'b0;  rx_push_data_q <= 8'h00;  rx_perr_q <= 1'b0;  rx_ferr_q <= 1'b0;
         overrun_q <= 1'b0;  parity_err_q <= 1'b0;  framing_err_q <= 1'b0;  irq_q <= 1'b0;
      end else begin
         ctrl_q <= ctrl_d;  div_q <= div_d;  baud_cnt_q <= baud_cnt_d;
         rx_meta_q <= rx;  rx_sync_q <= rx_meta_q;
         tx_state_q <= tx_state_d;  tx_q <= tx_d;  tx_shift_q <= tx_shift_d;  tx_bit_q <= tx_bit_d;
         tx_tick_q <= tx_tick_d;  tx_nbits_q <= tx_nbits_d;  tx_two_stop_q <= tx_two_stop_d;
         tx_par_en_q <= tx_par_en_d;  tx_par_q <= tx_par_d;  tx_stop2_q <= tx_stop2_d;
         rx_state_q <= rx_state_d;  rx_tick_q <= rx_tick_d;  rx_bit_q <= rx_bit_d;
         rx_shift_q <= rx_shift_d;  rx_nbits_q <= rx_nbits_d;  rx_par_en_q <= rx_par_en_d;
         rx_odd_q <= rx_odd_d;  rx_par_bit_q <= rx_par_bit_d;  rx_push_q <= rx_push_d;
         rx_push_data_q <= rx_push_data_d;  rx_perr_q <= rx_perr_d;  rx_ferr_q <= rx_ferr_d;
         overrun_q <= overrun_d;  parity_err_q <= parity_err_d;  framing_err_q <= framing_err_d;
         irq_q <= irq_d;
      end
   end
endmodule

// Byte FIFO: push on full succeeds only alongside a pop; a pop on empty is ignored.
module uart_fifo16x_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [7:0]    push_data,
   input  logic          pop,
   output logic [7:0]    head,
   output logic [AW:0]   count,
   output logic          empty,
   output logic          full
);
   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == (AW+1)'(DEPTH));
   assign count = cnt_q;
   assign head  = mem_q[rd_q];

   always_comb begin
      do_pop  = pop & ~empty;
      do_push = push & (~full | do_pop);
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      if (do_push) begin
         mem_d[wr_q] = push_data;
         wr_d        = wr_q + 1'b1;
      end
      if (do_pop) rd_d = rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) mem_q <= mem_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: tb/tb_uart_fifo16x.sv
// tb/tb_uart_fifo16x.sv - directed bench for uart_fifo16x: register table plus frame-level sequences.

module tb_uart_fifo16x;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       tx;
   logic [2:0] addr = 3'd0;
   logic       write_en = 1'b0;
   logic       read_en = 1'b0;
   logic [7:0] write_data = 8'h00;
   logic [7:0] read_data;
   logic       irq;

   int checks = 0;
   int errors = 0;
   int tx_falls = 0;
   logic tx_prev = 1'b1;

   uart_fifo16x #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd27)) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx), .addr(addr), .write_en(write_en),
      .read_en(read_en), .write_data(write_data), .read_data(read_data), .irq(irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      tx_prev <= tx;
      if (tx_prev && !tx) tx_falls <= tx_falls + 1;
   end

   typedef struct {
      logic       wr;
      logic [2:0] a;
      logic [7:0] d;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      addr = a; write_data = d; write_en = 1'b1;
      @(posedge clk); #1;
      write_en = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [7:0] d);
      addr = a;
      #1 d = read_data;
      @(posedge clk); #1;
   endtask

   task automatic pop(output logic [7:0] d);
      addr = 3'd0; read_en = 1'b1;
      #1 d = read_data;
      @(posedge clk); #1;
      read_en = 1'b0;
   endtask

   task automatic wait_idle(input int limit, input string name);
      int n = 0;
      addr = 3'd1;
      @(posedge clk); #1;
      while (read_data[7] !== 1'b1 && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
      chk(name, read_data[7], 1);
   endtask

   task automatic send_frame(input logic [7:0] d, input int nb, input bit pen,
                             input logic pbit, input logic stop);
      rx = 1'b0;
      repeat (16) @(posedge clk); #1;
      for (int i = 0; i < nb; i++) begin
         rx = d[i];
         repeat (16) @(posedge clk); #1;
      end
      if (pen) begin
         rx = pbit;
         repeat (16) @(posedge clk); #1;
      end
      rx = stop;
      repeat (16) @(posedge clk); #1;
      rx = 1'b1;
      repeat (6) @(posedge clk); #1;
   endtask

   task automatic measure_frame(input logic [7:0] ctrl, input int exp, input string name);
      int n = 0;
      wr(3'd2, ctrl);
      wr(3'd0, 8'h00);
      addr = 3'd1;
      while (tx !== 1'b0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      n = 0;
      while (read_data[7] !== 1'b1 && n < exp + 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk(name, n, exp);
   endtask

   vec_t vecs[$];
   logic [7:0] v;
   int f0;

   initial begin
      vecs = '{
         '{1'b0, 3'd1, 8'h81}, '{1'b0, 3'd2, 8'h03}, '{1'b0, 3'd3, 8'd27}, '{1'b0, 3'd4, 8'h00},
         '{1'b0, 3'd5, 8'h00}, '{1'b0, 3'd6, 8'h00}, '{1'b0, 3'd7, 8'h00}, '{1'b0, 3'd0, 8'h00},
         '{1'b1, 3'd2, 8'h3C}, '{1'b0, 3'd2, 8'h3C}, '{1'b1, 3'd2, 8'h03}, '{1'b0, 3'd2, 8'h03},
         '{1'b1, 3'd1, 8'h70}, '{1'b0, 3'd1, 8'h81}, '{1'b1, 3'd4, 8'h00}, '{1'b1, 3'd3, 8'h01},
         '{1'b0, 3'd3, 8'h01}, '{1'b0, 3'd4, 8'h00}, '{1'b1, 3'd7, 8'hFF}, '{1'b0, 3'd7, 8'h00}
      };

      repeat (3) @(posedge clk); #1;
      chk("reset_tx", tx, 1);
      chk("reset_irq", irq, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         if (vecs[i].wr) wr(vecs[i].a, vecs[i].d);
         else begin
            rd(vecs[i].a, v);
            chk($sformatf("vec%0d_addr%0d", i, vecs[i].a), v, vecs[i].d);
         end
      end

      // tx_ie with an empty TX FIFO raises irq one clock after the CTRL write.
      wr(3'd2, 8'h43);
      chk("irq_lag", irq, 0);
      @(posedge clk); #1;
      chk("irq_tx_ie", irq, 1);
      wr(3'd2, 8'h03);
      @(posedge clk); #1;
      chk("irq_tx_ie_off", irq, 0);

      measure_frame(8'h03, 160, "frame_8n1_clocks");
      measure_frame(8'h0F, 192, "frame_8e2_clocks");

      // Loopback 8N1, 0xA5.
      wr(3'd2, 8'h83);
      wr(3'd0, 8'hA5);
      rd(3'd1, v);
      chk("lb_tx_idle_drop", v[7], 0);
      wait_idle(400, "lb_wait_idle");
      rd(3'd5, v);  chk("lb_rx_level1", v, 1);
      pop(v);       chk("lb_data", v, 8'hA5);
      rd(3'd5, v);  chk("lb_rx_level0", v, 0);

      // Loopback 7O1 with 0xFF, then an externally corrupted parity bit.
      wr(3'd2, 8'h9A);
      wr(3'd0, 8'hFF);
      wait_idle(400, "par_wait_idle");
      pop(v);       chk("par_lb_data", v, 8'h7F);
      rd(3'd1, v);  chk("par_lb_perr", v[5], 0);
      wr(3'd2, 8'h1A);
      send_frame(8'h7F, 7, 1'b1, 1'b1, 1'b1);
      rd(3'd1, v);  chk("par_ext_perr", v[5], 1);
      rd(3'd5, v);  chk("par_ext_level", v, 1);
      pop(v);       chk("par_ext_data", v, 8'h7F);
      wr(3'd1, 8'h20);
      rd(3'd1, v);  chk("par_clear", v[5], 0);

      // Framing error with rx_ie=0 still interrupts; write-one clears it.
      wr(3'd2, 8'h03);
      @(posedge clk); #1;
      chk("fe_irq_before", irq, 0);
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
      rd(3'd1, v);  chk("fe_flag", v[6], 1);
      chk("fe_irq", irq, 1);
      pop(v);       chk("fe_data", v, 8'h3C);
      wr(3'd1, 8'h40);
      chk("fe_irq_lag", irq, 1);
      rd(3'd1, v);  chk("fe_cleared", v[6], 0);
      chk("fe_irq_clear", irq, 0);

      // A short glitch must not produce a byte; a following frame still lands cleanly.
      rx = 1'b0;
      repeat (4) @(posedge clk); #1;
      rx = 1'b1;
      repeat (30) @(posedge clk); #1;
      rd(3'd5, v);  chk("glitch_no_push", v, 0);
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
      rd(3'd5, v);  chk("glitch_next_level", v, 1);
      pop(v);       chk("glitch_next_data", v, 8'h3C);
      rd(3'd1, v);  chk("glitch_next_status", v & 8'h70, 0);

      // DEPTH+1 bytes looped back without reading: last one is lost.
      wr(3'd2, 8'h83);
      for (int i = 0; i <= DEPTH; i++) wr(3'd0, 8'h10 + 8'(i));
      wait_idle((DEPTH + 1) * 170, "ovr_wait_idle");
      rd(3'd5, v);  chk("ovr_rx_level", v, DEPTH);
      rd(3'd1, v);  chk("ovr_flag", v[4], 1);
      chk("ovr_rx_full", v[3], 1);
      for (int i = 0; i < DEPTH; i++) begin
         pop(v);
         chk($sformatf("ovr_data%0d", i), v, 8'h10 + 8'(i));
      end
      rd(3'd5, v);  chk("ovr_rx_level0", v, 0);
      wr(3'd1, 8'h10);

      // TX FIFO fill: one byte goes to the shifter, the FIFO holds DEPTH more, the rest drop.
      wr(3'd2, 8'h03);
      f0 = tx_falls;
      for (int i = 0; i < DEPTH; i++) wr(3'd0, 8'hFF);
      rd(3'd1, v);  chk("txf_not_full", v[1], 0);
      rd(3'd6, v);  chk("txf_level15", v, DEPTH - 1);
      wr(3'd0, 8'hFF);
      rd(3'd1, v);  chk("txf_full", v[1], 1);
      wr(3'd0, 8'hFF);
      rd(3'd6, v);  chk("txf_level_peak", v, DEPTH);
      wait_idle((DEPTH + 2) * 170, "txf_wait_idle");
      chk("txf_frames", tx_falls - f0, DEPTH + 1);

      // Reset in the middle of a frame.
      wr(3'd0, 8'h00);
      repeat (30) @(posedge clk); #1;
      chk("rst_mid_tx_low", tx, 0);
      rst_n = 1'b0;
      #1;
      chk("rst_tx_high", tx, 1);
      addr = 3'd1;
      #1;
      chk("rst_status", read_data, 8'h81);
      @(posedge clk); #1;
      rst_n = 1'b1;
      rd(3'd6, v);  chk("rst_tx_level", v, 0);
      rd(3'd2, v);  chk("rst_ctrl", v, 8'h03);
      rd(3'd3, v);  chk("rst_div_lo", v, 8'd27);
      chk("rst_irq", irq, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
